speed_pulse_tx: RTL and testbench

//  Transmit side of the single-wire speed-pulse interface: serialises speed commands onto the w line.

---
 rtl/speed_pulse_tx_pkg.sv | 16 +
 rtl/speed_pulse_tx_if.sv | 41 ++++
 rtl/speed_pulse_tx_pulse_down_cnt.sv | 28 ++
 rtl/speed_pulse_tx.sv | 153 +++++++++++++++
 tb/tb_speed_pulse_tx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/speed_pulse_tx_pkg.sv
// Shared types and defaults for the speed-pulse transmitter.
// SPG_ABORT_EN adds an abort input that cuts a command short.
package speed_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam int CNT_W_DEF   = 8;
   localparam int REP_W_DEF   = 4;
   localparam int GAP_LEN_DEF = 2;

endpackage

// File: rtl/speed_pulse_tx_if.sv
// Command/pulse bundle between speed-command logic and the transmitter.
// SPG_ABORT_EN adds the abort signal to the bundle.
interface speed_pulse_tx_if
   import speed_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int REP_W = REP_W_DEF
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_len;
   logic [REP_W-1:0] cmd_reps;
   logic             w;
   logic             busy;
   logic             done;
`ifdef SPG_ABORT_EN
   logic             abort;

   modport master (
      output cmd_valid, cmd_len, cmd_reps, abort,
      input  cmd_ready, w, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_len, cmd_reps, abort,
      output cmd_ready, w, busy, done
   );
`else
   modport master (
      output cmd_valid, cmd_len, cmd_reps,
      input  cmd_ready, w, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_len, cmd_reps,
      output cmd_ready, w, busy, done
   );
`endif

endinterface

// File: rtl/speed_pulse_tx_pulse_down_cnt.sv
// Loadable down-counter; o_tc flags a count of zero.
// Holds at zero rather than wrapping.
module pulse_down_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_bar,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge clr_bar) begin
      if (!clr_bar) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/speed_pulse_tx.sv
// Serialises speed commands into bursts of w-high cycles with low gaps.
// SPG_ABORT_EN enables the abort input that ends a command early.
module speed_pulse_tx
   import speed_ctrl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int REP_W   = REP_W_DEF,
   parameter int GAP_LEN = GAP_LEN_DEF
) (
   input  logic            clk,
   input  logic            clr_bar,
   speed_pulse_tx_if.slave bus
);

   localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_LEN - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_len;
   logic [REP_W-1:0] r_reps;
   logic             r_w;
   logic             r_busy;
   logic             r_done;
   logic             r_ready;

   logic             w_abort;
   logic             w_accept;
   logic             w_tc;
   logic             w_load;
   logic             w_dec;
   logic [CNT_W-1:0] w_val;

`ifdef SPG_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_accept = bus.cmd_valid && r_ready && (r_state == IDLE);

   // One counter serves both burst length and gap, as BURST and GAP never overlap.
   always_comb begin
      w_load = 1'b0;
      w_dec  = 1'b0;
      w_val  = '0;
      unique case (r_state)
         IDLE: begin
            if (w_accept && (bus.cmd_len != '0)) begin
               w_load = 1'b1;
               w_val  = bus.cmd_len - CNT_W'(1);
            end
         end
         BURST: begin
            if (w_abort || w_tc) begin
               w_load = 1'b1;
               w_val  = GAP_LD;
            end else begin
               w_dec = 1'b1;
            end
         end
         GAP: begin
            if (w_tc && (r_reps != '0) && !w_abort) begin
               w_load = 1'b1;
               w_val  = r_len - CNT_W'(1);
            end else begin
               w_dec = 1'b1;
            end
         end
         default: begin
            w_dec = 1'b0;
         end
      endcase
   end

   pulse_down_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .clr_bar (clr_bar),
      .i_load  (w_load),
      .i_val   (w_val),
      .i_dec   (w_dec),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clk or negedge clr_bar) begin
      if (!clr_bar) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_reps  <= '0;
         r_w     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_len   <= bus.cmd_len;
                  r_reps  <= bus.cmd_reps;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  if (bus.cmd_len != '0) begin
                     r_state <= BURST;
                     r_w     <= 1'b1;
                  end else begin
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end
               end
            end
            BURST: begin
               if (w_abort || w_tc) begin
                  r_state <= GAP;
                  r_w     <= 1'b0;
                  if (w_abort) begin
                     r_reps <= '0;
                  end
               end
            end
            GAP: begin
               if (w_tc) begin
                  if ((r_reps != '0) && !w_abort) begin
                     r_reps  <= r_reps - REP_W'(1);
                     r_state <= BURST;
                     r_w     <= 1'b1;
                  end else begin
                     r_reps  <= '0;
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end
               end else if (w_abort) begin
                  r_reps <= '0;
               end
            end
            FIN: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.w         = r_w;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.cmd_ready = r_ready;

endmodule

// File: tb/tb_speed_pulse_tx.sv
// Directed scoreboard bench for speed_pulse_tx.
// Define SPG_ABORT_EN to include the abort scenario.
module tb_speed_pulse_tx;

   localparam int GAP = 2;

   typedef struct packed {
      logic w;
      logic done;
      logic busy;
      logic ready;
   } exp_t;

   logic clk;
   logic clr_bar;
   int   checks;
   int   failures;
   exp_t q[$];

   speed_pulse_tx_if bus ();

   speed_pulse_tx dut (
      .clk     (clk),
      .clr_bar (clr_bar),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_w"}, bus.w, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_ready"}, bus.cmd_ready, 1'b1);
   endtask

   task automatic push(input logic w, input logic d, input logic b, input logic r);
      exp_t e;
      e.w     = w;
      e.done  = d;
      e.busy  = b;
      e.ready = r;
      q.push_back(e);
   endtask

   // Expected per-cycle outputs from the cycle after acceptance onward.
   task automatic push_cmd(input int len, input int reps);
      if (len != 0) begin
         for (int b = 0; b <= reps; b++) begin
            for (int i = 0; i < len; i++) push(1'b1, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < GAP; i++) push(1'b0, 1'b0, 1'b1, 1'b0);
         end
      end
      push(1'b0, 1'b1, 1'b1, 1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      e = q.pop_front();
      chk({tag, "_w"}, bus.w, e.w);
      chk({tag, "_done"}, bus.done, e.done);
      chk({tag, "_busy"}, bus.busy, e.busy);
      chk({tag, "_ready"}, bus.cmd_ready, e.ready);
   endtask

   task automatic drain(input string tag);
      while (q.size() > 0) begin
         pop_chk(tag);
         if (q.size() > 0) step();
      end
   endtask

   task automatic send(input int len, input int reps);
      bus.cmd_len   = len[7:0];
      bus.cmd_reps  = reps[3:0];
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      clr_bar       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_reps  = '0;
`ifdef SPG_ABORT_EN
      bus.abort     = 1'b0;
`endif
      step();
      chk_idle("rst_hold");
      step();
      #2 clr_bar = 1'b1;
      step();
      chk_idle("rst_rel");

      // len=3 reps=0
      push_cmd(3, 0);
      send(3, 0);
      drain("l3r0");

      // len=2 reps=2
      push_cmd(2, 2);
      send(2, 2);
      drain("l2r2");

      // len=0 is a no-op with one done pulse
      push_cmd(0, 5);
      send(0, 5);
      drain("l0r5");

      // isolated single-cycle pulses
      push_cmd(1, 2);
      send(1, 2);
      drain("l1r2");

      // valid held through a command with a different len
      push_cmd(4, 1);
      bus.cmd_len   = 8'd4;
      bus.cmd_reps  = 4'd1;
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_len   = 8'd6;
      bus.cmd_reps  = 4'd0;
      drain("hold_a");
      push_cmd(6, 0);
      step();
      bus.cmd_valid = 1'b0;
      drain("hold_b");
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle("hold_after");
      end

      // asynchronous reset in the middle of a burst
      send(10, 0);
      for (int i = 1; i <= 4; i++) begin
         chk("arst_pre_w", bus.w, 1'b1);
         if (i < 4) step();
      end
      #2 clr_bar = 1'b0;
      #1;
      chk_idle("arst_low");
      step();
      #2 clr_bar = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_idle("arst_after");
      end

`ifdef SPG_ABORT_EN
      // abort during the third high cycle of the first burst
      for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < GAP; i++) push(1'b0, 1'b0, 1'b1, 1'b0);
      push(1'b0, 1'b1, 1'b1, 1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b1);
      send(8, 3);
      pop_chk("abort");
      step();
      pop_chk("abort");
      step();
      pop_chk("abort");
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      drain("abort");
      for (int i = 0; i < 10; i++) begin
         step();
         chk_idle("abort_after");
      end
`endif

      // widest counters: nothing may wrap early
      push_cmd(255, 15);
      send(255, 15);
      drain("max");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
